// File: rtl/uart_pkg.sv
// uart_pkg: shared UART parity codes and transmitter state encoding
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with occupancy count and registered-only read side
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             system_clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge system_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
  assign dout = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: configurable-frame UART transmitter paced by baud_tick, fed from an internal FIFO
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 system_clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  output logic                 full,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 overflow,
  output logic                 tx,
  output logic                 tx_busy
);
  localparam int BW = $clog2(DATA_BITS);
  if (PARITY < 0 || PARITY > 2 || !(STOP_BITS == 1 || STOP_BITS == 2) || DATA_BITS < 5 || DATA_BITS > 9 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CNT_W != $clog2(FIFO_DEPTH) + 1) begin : g_bad_param
    $error("uart_tx_fifo: illegal parameter set");
  end
  tx_state_t state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, head;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic par_q, par_d, tx_q, tx_d, overflow_q, overflow_d;
  logic pop, empty, last_data, last_stop;
  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .system_clk(system_clk),
    .reset(reset),
    .push(wr_en),
    .pop(pop),
    .din(din),
    .dout(head),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
  assign last_data = bit_cnt_q == BW'(DATA_BITS - 1);
  assign last_stop = bit_cnt_q == BW'(STOP_BITS - 1);
  always_ff @(posedge system_clk) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_cnt_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q <= par_d;
      tx_q <= tx_d;
      overflow_q <= overflow_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (baud_tick) begin
      case (state_q)
        IDLE:             state_d = empty ? IDLE : START;
        START:            state_d = DATA;
        DATA:             state_d = !last_data ? DATA : PARITY != PAR_NONE ? uart_pkg::PARITY : STOP;
        uart_pkg::PARITY: state_d = STOP;
        STOP:             state_d = !last_stop ? STOP : empty ? IDLE : START;
        default:          state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    shift_d = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d = par_q;
    tx_d = tx_q;
    pop = 1'b0;
    overflow_d = wr_en && full;
    if (baud_tick) begin
      case (state_q)
        START: begin
          tx_d = shift_q[0];
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d = shift_q >> 1;
          tx_d = last_data ? (PARITY != PAR_NONE ? par_q : 1'b1) : shift_q[1];
          bit_cnt_d = last_data ? '0 : bit_cnt_q + 1'b1;
        end
        uart_pkg::PARITY: tx_d = 1'b1;
        STOP: bit_cnt_d = bit_cnt_q + 1'b1;
        default: ;
      endcase
      if (state_d == START) begin
        pop = 1'b1;
        shift_d = head;
        par_d = (^head) ^ (PARITY == PAR_ODD);
        tx_d = 1'b0;
      end
    end
  end
  assign tx = tx_q;
  assign overflow = overflow_q;
  assign tx_busy = state_q != IDLE || !empty;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench decoding serial frames from five differently configured transmitters
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic reset, baud_tick, tick_en;
  logic [8:0] din;
  logic wr_en [5];
  logic full [5];
  logic overflow [5];
  logic tx [5];
  logic tx_busy [5];
  logic [4:0] fifo_count [5];
  int vectors = 0;
  int miscompares = 0;
  int tcnt = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int DB = g == 3 ? 7 : 8;
    localparam int PB = g == 1 ? 2 : (g == 2 || g == 3) ? 1 : 0;
    localparam int SB = g == 3 ? 2 : 1;
    localparam int FD = g == 4 ? 4 : 16;
    localparam int CW = $clog2(FD) + 1;
    localparam int FL = 1 + DB + (PB != 0 ? 1 : 0) + SB;
    logic [CW-1:0] cnt;
    string qb [$];
    bit qg [$];
    uart_tx_fifo #(.DATA_BITS(DB), .PARITY(PB), .STOP_BITS(SB), .FIFO_DEPTH(FD)) u_dut (
      .system_clk(clk),
      .reset(reset),
      .baud_tick(baud_tick),
      .din(din[DB-1:0]),
      .wr_en(wr_en[g]),
      .full(full[g]),
      .fifo_count(cnt),
      .overflow(overflow[g]),
      .tx(tx[g]),
      .tx_busy(tx_busy[g])
    );
    assign fifo_count[g] = 5'(cnt);
    task automatic expect_frame(input string b, input bit b2b);
      qb.push_back(b);
      qg.push_back(b2b);
    endtask
    task automatic check_drained();
      vectors++;
      if (qb.size() != 0) begin
        miscompares++;
        $display("FAIL drain[%0d]: %0d frames never seen, required 0", g, qb.size());
      end
    endtask
    initial begin : mon
      string bits, eb;
      int n, tick_i, start_i, end_i;
      bit tk, rs, held, glitch, b2b, eg;
      n = 0; tick_i = 0; start_i = 0; end_i = -10; held = 1'b1; glitch = 1'b0; bits = "";
      forever begin
        @(posedge clk);
        tk = baud_tick;
        rs = reset;
        #1;
        if (!rs) begin
          n = 0;
          held = tx[g];
          glitch = 1'b0;
          end_i = -10;
          continue;
        end
        if (!tk) begin
          if (tx[g] != held) glitch = 1'b1;
          continue;
        end
        tick_i++;
        held = tx[g];
        if (n == 0) begin
          if (tx[g] == 1'b0) begin
            n = 1;
            bits = "0";
            start_i = tick_i;
          end
        end else begin
          bits = $sformatf("%s%0d", bits, tx[g]);
          n++;
          if (n == FL) begin
            b2b = start_i == end_i + 1;
            vectors++;
            if (qb.size() == 0) begin
              miscompares++;
              $display("FAIL frame[%0d]: got %s, required no frame", g, bits);
            end else begin
              eb = qb.pop_front();
              eg = qg.pop_front();
              if (bits != eb || b2b != eg || glitch) begin
                miscompares++;
                $display("FAIL frame[%0d]: got %s b2b=%0d offtick_change=%0d, required %s b2b=%0d offtick_change=0",
                         g, bits, b2b, glitch, eb, eg);
              end
            end
            glitch = 1'b0;
            n = 0;
            end_i = tick_i;
          end
        end
      end
    end
  end
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt = tcnt == 15 ? 0 : tcnt + 1;
      baud_tick = tick_en && tcnt == 15;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish within time limit");
    $fatal(1, "watchdog expired");
  end
  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask
  task automatic tick_sync();
    do @(posedge clk); while (!baud_tick);
    #1;
  endtask
  task automatic put(input int g, input logic [8:0] d);
    @(negedge clk);
    din = d;
    wr_en[g] = 1'b1;
    @(posedge clk);
    #1;
    wr_en[g] = 1'b0;
  endtask
  task automatic wait_idle(input int g, output int ticks);
    ticks = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      if (baud_tick) ticks++;
      #1;
      if (!tx_busy[g]) return;
    end
    ticks = -1;
  endtask
  initial begin
    int t;
    reset = 1'b0;
    tick_en = 1'b1;
    din = '0;
    foreach (wr_en[i]) wr_en[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("reset_tx[%0d]", g), tx[g], 1);
      chk($sformatf("reset_count[%0d]", g), fifo_count[g], 0);
      chk($sformatf("reset_full[%0d]", g), full[g], 0);
      chk($sformatf("reset_overflow[%0d]", g), overflow[g], 0);
      chk($sformatf("reset_busy[%0d]", g), tx_busy[g], 0);
    end
    reset = 1'b1;
    tick_sync();
    g_dut[0].expect_frame("0101001011", 1'b0);
    put(0, 9'h0A5);
    chk("t1_busy", tx_busy[0], 1);
    chk("t1_count", fifo_count[0], 1);
    wait_idle(0, t);
    chk("t1_ticks_to_idle", t, 11);
    chk("t1_tx_idle", tx[0], 1);
    tick_sync();
    g_dut[1].expect_frame("01010010101", 1'b0);
    g_dut[2].expect_frame("01010010111", 1'b0);
    g_dut[3].expect_frame("01010110111", 1'b0);
    put(1, 9'h0A5);
    put(2, 9'h0A5);
    put(3, 9'h035);
    wait_idle(3, t);
    chk("t3_ticks_to_idle", t, 12);
    wait_idle(1, t);
    chk("t2_even_busy", tx_busy[1], 0);
    wait_idle(2, t);
    chk("t2_odd_busy", tx_busy[2], 0);
    tick_sync();
    g_dut[0].expect_frame("0100000001", 1'b0);
    g_dut[0].expect_frame("0010000001", 1'b1);
    g_dut[0].expect_frame("0110000001", 1'b1);
    put(0, 9'h001);
    chk("t4_count_w1", fifo_count[0], 1);
    put(0, 9'h002);
    chk("t4_count_w2", fifo_count[0], 2);
    put(0, 9'h003);
    chk("t4_count_w3", fifo_count[0], 3);
    tick_sync();
    chk("t4_count_f1", fifo_count[0], 2);
    repeat (10) tick_sync();
    chk("t4_count_f2", fifo_count[0], 1);
    repeat (10) tick_sync();
    chk("t4_count_f3", fifo_count[0], 0);
    wait_idle(0, t);
    chk("t4_ticks_last_frame", t, 10);
    @(negedge clk);
    tick_en = 1'b0;
    repeat (2) @(negedge clk);
    g_dut[4].expect_frame("0100010001", 1'b0);
    g_dut[4].expect_frame("0010001001", 1'b1);
    g_dut[4].expect_frame("0110011001", 1'b1);
    g_dut[4].expect_frame("0001000101", 1'b1);
    put(4, 9'h011);
    chk("t5_full_w1", full[4], 0);
    put(4, 9'h022);
    put(4, 9'h033);
    chk("t5_full_w3", full[4], 0);
    put(4, 9'h044);
    chk("t5_full_w4", full[4], 1);
    chk("t5_count_w4", fifo_count[4], 4);
    chk("t5_ovf_w4", overflow[4], 0);
    put(4, 9'h055);
    chk("t5_ovf_w5", overflow[4], 1);
    chk("t5_count_w5", fifo_count[4], 4);
    put(4, 9'h066);
    chk("t5_ovf_w6", overflow[4], 1);
    @(posedge clk);
    #1;
    chk("t5_ovf_clear", overflow[4], 0);
    chk("t5_count_hold", fifo_count[4], 4);
    tick_en = 1'b1;
    wait_idle(4, t);
    chk("t5_ticks_to_idle", t, 41);
    repeat (15) tick_sync();
    chk("t5_count_end", fifo_count[4], 0);
    tick_sync();
    put(0, 9'h007);
    put(0, 9'h00F);
    put(0, 9'h0F0);
    chk("t6_count_queued", fifo_count[0], 3);
    repeat (5) tick_sync();
    chk("t6_tx_bit3", tx[0], 0);
    chk("t6_count_mid", fifo_count[0], 2);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("t6_tx_after_reset", tx[0], 1);
    chk("t6_count_after_reset", fifo_count[0], 0);
    chk("t6_busy_after_reset", tx_busy[0], 0);
    repeat (25) tick_sync();
    chk("t6_tx_quiet", tx[0], 1);
    chk("t6_busy_quiet", tx_busy[0], 0);
    g_dut[0].check_drained();
    g_dut[1].check_drained();
    g_dut[2].check_drained();
    g_dut[3].check_drained();
    g_dut[4].check_drained();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the team's 8N1 UART transmitter. Frame format is configurable: data width, parity mode and stop-bit count. Includes an internal transmit FIFO. Runs entirely in the system_clk domain; bit timing comes from a single-cycle baud_tick enable, not a derived clock. Sits between the host-side byte writer and the board TX pin, fed by the shared baud generator.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame, 1 or 2
FIFO_DEPTH, 16, TX FIFO entries, power of 2, at least 2
CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count

Ports:
system_clk  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-low
baud_tick  in  1  one-cycle pulse per bit period, from the baud generator
din  in  DATA_BITS  word to transmit
wr_en  in  1  push din into FIFO this cycle
full  out  1  FIFO full; a push this cycle is dropped
fifo_count  out  CNT_W  current FIFO occupancy, 0..FIFO_DEPTH
overflow  out  1  one-cycle pulse when wr_en is asserted while full
tx  out  1  serial line, idle high
tx_busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty

Behaviour:
- Reset (reset == 0 at a system_clk edge):
  - tx = 1, state = IDLE, FIFO flushed (fifo_count = 0), full = 0, overflow = 0, tx_busy = 0.
  - Applies mid-frame: the line returns high on the next edge, and the partial frame is abandoned.
- FIFO push:
  - wr_en && !full writes din; fifo_count increments on the next edge.
  - full is evaluated from pre-edge state. A push while full is dropped even if a pop occurs in the same cycle; overflow pulses for 1 cycle.
  - No fall-through: a word is poppable no earlier than the cycle after it is written.
- FSM states: IDLE, START, DATA, PARITY, STOP. tx is registered; all transitions occur only in cycles with baud_tick = 1.
  - IDLE: on a baud_tick with FIFO non-empty, pop the head into the shift register, tx <= 0, go to START. Worst-case latency from write to start bit is 1 baud period plus 1 cycle.
  - START: on the tick, tx <= shift[0] (LSB first), bit counter = 0, go to DATA.
  - DATA: on each tick, shift and drive the next bit. After DATA_BITS bits have each held one period:
    - PARITY != 0: tx <= parity bit (odd: XOR of data bits inverted; even: XOR), go to PARITY.
    - PARITY == 0: tx <= 1, go to STOP.
  - PARITY: on the tick, tx <= 1, go to STOP.
  - STOP: holds for STOP_BITS tick periods. On the tick ending the last stop bit:
    - FIFO non-empty: pop, tx <= 0, go to START (back-to-back, no idle gap).
    - Otherwise: go to IDLE with tx staying 1.
- Frame length: exactly 1 + DATA_BITS + (PARITY ? 1 : 0) + STOP_BITS tick periods; every bit is held for one full tick-to-tick interval.
- fifo_count:
  - Simultaneous push and pop leaves the count unchanged.
  - Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - full = (count == FIFO_DEPTH).
- baud_tick while reset is low is ignored. A tick arriving in IDLE with the FIFO empty does nothing.
- Illegal parameter values (PARITY > 2, STOP_BITS not 1 or 2) cause an elaboration-time error.

Decomposition:
- Shared package uart_pkg:
  - parity localparams PAR_NONE / PAR_ODD / PAR_EVEN
  - FSM state encoding (tx_state_t: IDLE, START, DATA, PARITY, STOP), reused later by the receiver.
- One sub-module: uart_sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, count, full, empty), instantiated with WIDTH = DATA_BITS.
- Framing FSM stays in uart_tx_fifo.

Test Plan:
1. 8N1, baud_tick every 16 clks, write 0xA5 → tx = 0 | 1,0,1,0,0,1,0,1 | 1, each bit 16 clks; tx_busy drops after the stop bit.
2. PARITY = 2 (8E1), write 0xA5 → parity bit 0 after the data bits. Same frame with PARITY = 1 → parity bit 1.
3. DATA_BITS = 7, PARITY = 1, STOP_BITS = 2, write 0x35 → start 0, data 1,0,1,0,1,1,0, parity 1, then stop high for 2 periods; frame is 11 periods.
4. Write 0x01, 0x02, 0x03 on consecutive clocks → three 10-period frames with the start bit immediately after each stop bit (30 periods, no gap); fifo_count goes 1, 2, 3, then decrements at each frame start.
5. FIFO_DEPTH = 4, baud_tick held low, write 6 words → full after the 4th; overflow pulses on writes 5 and 6; only the first 4 words are transmitted once ticks resume.
6. Assert reset low for 1 cycle during data bit 3 with 2 words queued → tx = 1 next cycle, fifo_count = 0, tx_busy = 0; no further frames follow.
